// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter in front of a single-port data memory.
//
// Master 0 is the core and master 1 is the host loader/dump port. An owner
// register chooses which master drives the memory port. A master's grant is
// combinational: it is high when that master owns the port and requests it.
// Read data is captured on a read grant. It is returned the next cycle with a
// one-cycle rvalid pulse, and it holds until the next read by the same master.
//
// Ports:
//   Clk, Reset_n                   clock, asynchronous active-low reset
//   mX_req/mX_we/mX_addr/mX_wdata  master X request, held stable until mX_gnt
//   mX_gnt                         transfer done this cycle
//   mX_rvalid/mX_rdata             read data return, one cycle after the grant
//   mX_lock                        burst hold request (DM_ARB_LOCK_EN only)
//   dm_we/dm_addr/dm_wdata         DataMem port, zero while idle
//   dm_rdata                       combinational DataMem read data
//
// Build option: define DM_ARB_LOCK_EN to add the mX_lock inputs. A locked
// grant keeps ownership with that master for up to 8 consecutive grants.
//
// state | meaning
// IDLE  | no owner, memory port quiet
// OWN0  | core (m0) drives the memory port
// OWN1  | host (m1) drives the memory port

module dm_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
`ifdef DM_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    owner_t owner_q, owner_d;
    // 0: m0 was served last, 1: m1 was served last
    logic   last_q, last_d;
`ifdef DM_ARB_LOCK_EN
    logic [2:0] lock_cnt_q, lock_cnt_d;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_q    <= IDLE;
            last_q     <= 1'b1;
`ifdef DM_ARB_LOCK_EN
            lock_cnt_q <= 3'd0;
`endif
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
`ifdef DM_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        m0_gnt   = (owner_q == OWN0) && m0_req;
        m1_gnt   = (owner_q == OWN1) && m1_req;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        case (owner_q)
            OWN0: begin
                dm_we    = m0_we && m0_req;
                dm_addr  = m0_addr;
                dm_wdata = m0_wdata;
            end
            OWN1: begin
                dm_we    = m1_we && m1_req;
                dm_addr  = m1_addr;
                dm_wdata = m1_wdata;
            end
            default: ;
        endcase

        // A grant in this cycle counts as "last served" for the tie-break.
        // This makes two contending masters alternate every cycle.
        last_d = last_q;
        if (m0_gnt) begin
            last_d = 1'b0;
        end else if (m1_gnt) begin
            last_d = 1'b1;
        end

        if (m0_req && m1_req) begin
            owner_d = last_d ? OWN0 : OWN1;
        end else if (m0_req) begin
            owner_d = OWN0;
        end else if (m1_req) begin
            owner_d = OWN1;
        end else begin
            owner_d = IDLE;
        end

`ifdef DM_ARB_LOCK_EN
        // The counter holds the number of locked grants already served.
        // The 8th locked grant (count 7) releases ownership through the
        // normal round-robin path above.
        lock_cnt_d = 3'd0;
        if (((m0_gnt && m0_lock) || (m1_gnt && m1_lock)) && (lock_cnt_q != 3'd7)) begin
            owner_d    = owner_q;
            lock_cnt_d = lock_cnt_q + 3'd1;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= dm_rdata;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios with literal expectations,
// plus a per-cycle reference model of the arbitration rules and memory.

module tb_dm_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic       dm_we;
    logic [7:0] dm_addr, dm_wdata, dm_rdata;
`ifdef DM_ARB_LOCK_EN
    logic       m0_lock, m1_lock;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(8), .DW(8)) dut (
        .Clk(clk), .Reset_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    function automatic logic [7:0] init_val(int i);
        return (i == 16) ? 8'hA5 : (8'(i) ^ 8'h5A);
    endfunction

    // Data memory behind the arbiter: combinational read, clocked write.
    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. The "turn" is the master allowed to transfer this
    // cycle (-1 = none). It is advanced after each cycle from the requests
    // and from who was served.
    int         turn = -1;
    int         last = 1;
    int         streak = 0;
    bit         ev0 = 1'b0, ev1 = 1'b0;
    logic [7:0] erd0 = 8'h00, erd1 = 8'h00;
    logic [7:0] ref_mem [256];
    bit         ref_ready = 1'b0;

    always @(negedge clk) begin
        bit         eg0, eg1, ewe, lk;
        logic [7:0] ea, ed;
        int         g;
        if (!ref_ready) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_ready = 1'b1;
        end
        if (!rst_n) begin
            turn = -1; last = 1; streak = 0;
            ev0 = 1'b0; ev1 = 1'b0; erd0 = 8'h00; erd1 = 8'h00;
        end
        eg0 = (turn == 0) && m0_req;
        eg1 = (turn == 1) && m1_req;
        ewe = 1'b0; ea = 8'h00; ed = 8'h00;
        if (turn == 0) begin ewe = m0_we && m0_req; ea = m0_addr; ed = m0_wdata; end
        if (turn == 1) begin ewe = m1_we && m1_req; ea = m1_addr; ed = m1_wdata; end
        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        chk("m0_rvalid", m0_rvalid, ev0);
        chk("m1_rvalid", m1_rvalid, ev1);
        chk("m0_rdata", m0_rdata, erd0);
        chk("m1_rdata", m1_rdata, erd1);
        chk("dm_we", dm_we, ewe);
        chk("dm_addr", dm_addr, ea);
        chk("dm_wdata", dm_wdata, ed);
        if (rst_n) begin
            g = eg0 ? 0 : (eg1 ? 1 : -1);
            ev0 = (g == 0) && !m0_we;
            ev1 = (g == 1) && !m1_we;
            if (ev0) erd0 = ref_mem[m0_addr];
            if (ev1) erd1 = ref_mem[m1_addr];
            if (g == 0 && m0_we) ref_mem[m0_addr] = m0_wdata;
            if (g == 1 && m1_we) ref_mem[m1_addr] = m1_wdata;
            if (g >= 0) last = g;
            lk = 1'b0;
`ifdef DM_ARB_LOCK_EN
            lk = (g == 0) ? m0_lock : ((g == 1) ? m1_lock : 1'b0);
`endif
            if (g >= 0 && lk && (streak + 1 < 8)) begin
                streak++;
            end else begin
                streak = 0;
                if (m0_req && m1_req) turn = 1 - last;
                else if (m0_req)      turn = 0;
                else if (m1_req)      turn = 1;
                else                  turn = -1;
            end
        end
    end

    task automatic sample(); @(negedge clk); #1; endtask
    task automatic drive();  @(posedge clk); #1; endtask
    task automatic idle(input int n); repeat (n) begin sample(); drive(); end endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
`ifdef DM_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        sample();
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_dm_we", dm_we, 0);
        drive();
        sample();
        drive();
        rst_n = 1'b1;
    endtask

    task automatic xfer(input int m, input logic we, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        bit got = 1'b0;
        if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        while (!got && n < 20) begin
            sample();
            got = (m == 0) ? m0_gnt : m1_gnt;
            n++;
            if (!got) drive();
        end
        if (!got) chk("xfer_grant_timeout", 0, 1);
        drive();
        if (m == 0) m0_req = 0; else m1_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tie [5]    = '{-1, 0, 1, 0, 1};
        int exp_g4 [6]     = '{0, 1, 1, 1, 1, 0};
        int exp_v4 [6]     = '{0, 0, 1, 1, 1, 1};
        logic [7:0] rd4[4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
        int who;

        rst_n = 1'b0;
        clear_inputs();
        sample();
        drive();
        do_reset();

        // Single read from reset: grant one cycle after req, data the cycle after.
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        sample(); chk("rd_c0_gnt", m0_gnt, 0);
        drive();
        sample(); chk("rd_c1_gnt", m0_gnt, 1);
        drive(); m0_req = 0;
        sample(); chk("rd_c2_rvalid", m0_rvalid, 1); chk("rd_c2_rdata", m0_rdata, 8'hA5);
        drive();
        sample(); chk("rd_c3_rvalid", m0_rvalid, 0); chk("rd_c3_rdata_hold", m0_rdata, 8'hA5);
        drive();
        idle(2);

        // Both masters request together from reset: m0 first, then alternate.
        do_reset();
        m0_req = 1; m0_addr = 8'h01; m1_req = 1; m1_addr = 8'h02;
        for (int c = 0; c < 5; c++) begin
            sample();
            who = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
            chk($sformatf("tie_c%0d", c), who, exp_tie[c]);
            drive();
        end
        m0_req = 0; m1_req = 0;
        idle(3);

        // Host write, then core read of the same location.
        xfer(1, 1'b1, 8'h20, 8'h3C);
        xfer(0, 1'b0, 8'h20, 8'h00);
        sample();
        chk("wr_rd_rvalid", m0_rvalid, 1);
        chk("wr_rd_rdata", m0_rdata, 8'h3C);
        chk("wr_no_m1_rvalid", m1_rvalid, 0);
        drive();
        idle(2);

        // Four back-to-back reads by m0 alone.
        for (int c = 0; c < 6; c++) begin
            m0_req = (c < 5); m0_we = 0;
            m0_addr = (c == 0) ? 8'h00 : 8'(c - 1);
            sample();
            chk($sformatf("b2b_gnt_c%0d", c), m0_gnt, exp_g4[c]);
            chk($sformatf("b2b_rvalid_c%0d", c), m0_rvalid, exp_v4[c]);
            if (c >= 2) chk($sformatf("b2b_rdata_c%0d", c), m0_rdata, rd4[c - 2]);
            drive();
        end
        m0_req = 0;
        idle(2);

        // Reset the cycle after a read grant, with a write request pending.
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        sample(); chk("rst_mid_c0_gnt", m0_gnt, 0);
        drive();
        sample(); chk("rst_mid_c1_gnt", m0_gnt, 1);
        drive();
        rst_n = 0; m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'hEE;
        sample();
        chk("rst_mid_rvalid", m0_rvalid, 0);
        chk("rst_mid_rdata", m0_rdata, 0);
        chk("rst_mid_gnt", m0_gnt, 0);
        chk("rst_mid_dm_we", dm_we, 0);
        chk("rst_mid_dm_addr", dm_addr, 0);
        drive();
        sample(); chk("rst_mid_dm_we2", dm_we, 0);
        drive();
        rst_n = 1; m0_req = 0; m0_we = 0;
        idle(2);
        chk("rst_mid_mem_untouched", mem[8'h30], 8'h6A);

`ifdef DM_ARB_LOCK_EN
        begin
            int exp_lk [12] = '{-1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
            do_reset();
            for (int c = 0; c < 12; c++) begin
                m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 8'h40;
                m0_req = (c >= 1 && c <= 9); m0_we = 0; m0_addr = 8'h41;
                sample();
                who = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
                chk($sformatf("lock_c%0d", c), who, exp_lk[c]);
                drive();
            end
            clear_inputs();
            idle(2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
